xor_cipher: RTL and testbench

Symmetric XOR stream cipher datapath. Each accepted data word is XORed with the current key to produce the output word. The same block performs both encryption and decryption: two instances loaded with the same key and fed the same number of beats are exact inverses. It sits as a single-stage, registered, valid/ready pipeline element in the streaming datapath.

---
 rtl/xor_cipher_pkg.sv | 16 +
 rtl/xor_cipher_key_sched.sv | 47 ++++
 rtl/xor_cipher.sv | 56 +++++
 tb/tb_xor_cipher.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/xor_cipher_pkg.sv
// Shared constants and the key rotation helper for the XOR stream cipher.
package xor_cipher_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT  = 16;
  localparam int unsigned ROT_MAX_W      = 64;

  // Rotate the low w bits of x left by one; bits above w must be zero on entry.
  function automatic logic [ROT_MAX_W-1:0] rotl1(input logic [ROT_MAX_W-1:0] x,
                                                 input int unsigned         w);
    logic [ROT_MAX_W-1:0] mask;
    mask = (w >= ROT_MAX_W) ? '1 : ((ROT_MAX_W'(1) << w) - ROT_MAX_W'(1));
    return ((x << 1) | (x >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/xor_cipher_key_sched.sv
// Key register, optional per-beat rotation and accepted-beat counter.
module xor_cipher_key_sched
  import xor_cipher_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEFAULT,
  parameter bit          KEY_ROTATE = 1'b0,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] key,
  input  logic              key_load,
  input  logic              accept,
  output logic [DATA_W-1:0] key_eff_c,
  output logic [CNT_W-1:0]  beat_count
);

  logic [DATA_W-1:0] key_q;
  logic [DATA_W-1:0] key_rot_c;

  // A key loaded this cycle already applies to a beat accepted this cycle.
  assign key_eff_c = key_load ? key : key_q;
  assign key_rot_c = DATA_W'(rotl1(ROT_MAX_W'(key_eff_c), DATA_W));

  // Key register: rotation of the effective key covers both load+accept and plain accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
    end else if (KEY_ROTATE && accept) begin
      key_q <= key_rot_c;
    end else if (key_load) begin
      key_q <= key;
    end
  end

  // Beat counter: cleared by a key load (counting a coincident beat), wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count <= '0;
    end else if (key_load) begin
      beat_count <= CNT_W'(accept);
    end else if (accept) begin
      beat_count <= beat_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/xor_cipher.sv
// Single-stage registered valid/ready XOR cipher; encrypts and decrypts alike.
module xor_cipher
  import xor_cipher_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEFAULT,
  parameter bit          KEY_ROTATE = 1'b0,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] key,
  input  logic              key_load,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  beat_count
);

  logic              accept_c;
  logic [DATA_W-1:0] key_eff_c;

  // Ready whenever the output slot is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

  xor_cipher_key_sched #(
    .DATA_W     (DATA_W),
    .KEY_ROTATE (KEY_ROTATE),
    .CNT_W      (CNT_W)
  ) u_key_sched (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .key_load   (key_load),
    .accept     (accept_c),
    .key_eff_c  (key_eff_c),
    .beat_count (beat_count)
  );

  // Output register: load on accept, otherwise drop valid once drained; data holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else if (accept_c) begin
      data_out  <= data_in ^ key_eff_c;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_cipher.sv
// Bench for xor_cipher: static and rotating encrypt/decrypt chains plus a
// small-counter rotating instance for handshake corners and random traffic.
module tb_xor_cipher;
  import xor_cipher_pkg::*;

  logic clk;
  logic rst;

  // Shared stimulus for the two chains
  logic       key_load, in_valid, dec_ready;
  logic [7:0] key, data_in;
  logic       key_load_d;
  logic [7:0] key_d;

  logic        s_e_in_ready, s_e_out_valid, s_d_in_ready, s_d_out_valid;
  logic [7:0]  s_e_data_out, s_d_data_out;
  logic [15:0] s_e_cnt, s_d_cnt;
  logic        r_e_in_ready, r_e_out_valid, r_d_in_ready, r_d_out_valid;
  logic [7:0]  r_e_data_out, r_d_data_out;
  logic [15:0] r_e_cnt, r_d_cnt;

  // Standalone instance (rotating key, 4-bit counter)
  logic       w_key_load, w_in_valid, w_out_ready, w_in_ready, w_out_valid;
  logic [7:0] w_key, w_data_in, w_data_out;
  logic [3:0] w_cnt;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic        kl;
    logic [7:0]  key;
    logic [7:0]  data;
    logic [7:0]  exp_s;
    logic [7:0]  exp_r;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[7];

  xor_cipher #(.DATA_W(8), .KEY_ROTATE(1'b0), .CNT_W(16)) u_s_enc (
    .clk(clk), .rst(rst), .key(key), .key_load(key_load),
    .in_valid(in_valid), .in_ready(s_e_in_ready), .data_in(data_in),
    .out_valid(s_e_out_valid), .out_ready(s_d_in_ready),
    .data_out(s_e_data_out), .beat_count(s_e_cnt));

  xor_cipher #(.DATA_W(8), .KEY_ROTATE(1'b0), .CNT_W(16)) u_s_dec (
    .clk(clk), .rst(rst), .key(key_d), .key_load(key_load_d),
    .in_valid(s_e_out_valid), .in_ready(s_d_in_ready), .data_in(s_e_data_out),
    .out_valid(s_d_out_valid), .out_ready(dec_ready),
    .data_out(s_d_data_out), .beat_count(s_d_cnt));

  xor_cipher #(.DATA_W(8), .KEY_ROTATE(1'b1), .CNT_W(16)) u_r_enc (
    .clk(clk), .rst(rst), .key(key), .key_load(key_load),
    .in_valid(in_valid), .in_ready(r_e_in_ready), .data_in(data_in),
    .out_valid(r_e_out_valid), .out_ready(r_d_in_ready),
    .data_out(r_e_data_out), .beat_count(r_e_cnt));

  xor_cipher #(.DATA_W(8), .KEY_ROTATE(1'b1), .CNT_W(16)) u_r_dec (
    .clk(clk), .rst(rst), .key(key_d), .key_load(key_load_d),
    .in_valid(r_e_out_valid), .in_ready(r_d_in_ready), .data_in(r_e_data_out),
    .out_valid(r_d_out_valid), .out_ready(dec_ready),
    .data_out(r_d_data_out), .beat_count(r_d_cnt));

  xor_cipher #(.DATA_W(8), .KEY_ROTATE(1'b1), .CNT_W(4)) u_w (
    .clk(clk), .rst(rst), .key(w_key), .key_load(w_key_load),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .data_in(w_data_in),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .data_out(w_data_out), .beat_count(w_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decryptors see the key one cycle late, when the matching beat reaches them.
  always @(posedge clk) begin
    key_d      <= key;
    key_load_d <= key_load;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic w_drive(input logic vld, input logic [7:0] d, input logic kl,
                         input logic [7:0] k, input logic ordy);
    w_in_valid  = vld;
    w_data_in   = d;
    w_key_load  = kl;
    w_key       = k;
    w_out_ready = ordy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] m_key, m_d, keff;
  logic       m_v, acc, exp_rdy;
  int         m_cnt;

  initial begin
    rst = 1'b1; key_load = 1'b0; in_valid = 1'b0; dec_ready = 1'b1;
    key = 8'h00; data_in = 8'h00;
    w_drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    vecs[0] = '{1'b1, 8'hCC, 8'hAA, 8'h66, 8'h66, 16'd1};
    vecs[1] = '{1'b0, 8'h00, 8'hAA, 8'h66, 8'h33, 16'd2};
    vecs[2] = '{1'b1, 8'h0F, 8'hF0, 8'hFF, 8'hFF, 16'd1};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 8'h0F, 8'h1E, 16'd2};
    vecs[4] = '{1'b0, 8'h00, 8'h3C, 8'h33, 8'h00, 16'd3};
    vecs[5] = '{1'b1, 8'h81, 8'h01, 8'h80, 8'h80, 16'd1};
    vecs[6] = '{1'b0, 8'h00, 8'hFF, 8'h7E, 8'hFC, 16'd2};

    do_reset();
    chk("reset_out_valid", 32'(s_e_out_valid), 32'd0);
    chk("reset_data_out",  32'(s_e_data_out), 32'd0);
    chk("reset_count",     32'(r_e_cnt), 32'd0);
    chk("reset_in_ready",  32'(r_e_in_ready), 32'd1);

    // Back-to-back table through both chains at full throughput
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; data_in = vecs[i].data;
      key_load = vecs[i].kl; key = vecs[i].key;
      tick();
      chk("s_enc_data",  32'(s_e_data_out), 32'(vecs[i].exp_s));
      chk("r_enc_data",  32'(r_e_data_out), 32'(vecs[i].exp_r));
      chk("s_enc_valid", 32'(s_e_out_valid), 32'd1);
      chk("s_enc_count", 32'(s_e_cnt), 32'(vecs[i].cnt));
      chk("r_enc_count", 32'(r_e_cnt), 32'(vecs[i].cnt));
      if (i > 0) begin
        chk("s_dec_data",  32'(s_d_data_out), 32'(vecs[i-1].data));
        chk("r_dec_data",  32'(r_d_data_out), 32'(vecs[i-1].data));
        chk("r_dec_count", 32'(r_d_cnt), 32'(vecs[i-1].cnt));
      end
    end
    in_valid = 1'b0; key_load = 1'b0;
    tick();
    chk("s_dec_last",      32'(s_d_data_out), 32'(vecs[6].data));
    chk("r_dec_last",      32'(r_d_data_out), 32'(vecs[6].data));
    chk("r_dec_valid",     32'(r_d_out_valid), 32'd1);
    chk("enc_drained",     32'(s_e_out_valid), 32'd0);

    // Backpressure with a key load while the result is held
    do_reset();
    w_drive(1'b1, 8'hAA, 1'b1, 8'hCC, 1'b0);
    tick();
    chk("bp_first_data",  32'(w_data_out), 32'h66);
    chk("bp_first_valid", 32'(w_out_valid), 32'd1);
    for (int j = 0; j < 5; j++) begin
      w_drive(1'b1, 8'h11, j == 2, 8'h55, 1'b0);
      #1;
      chk("bp_in_ready", 32'(w_in_ready), 32'd0);
      tick();
      chk("bp_hold_data",  32'(w_data_out), 32'h66);
      chk("bp_hold_valid", 32'(w_out_valid), 32'd1);
      chk("bp_hold_count", 32'(w_cnt), (j >= 2) ? 32'd0 : 32'd1);
    end
    w_drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    #1;
    chk("bp_release_ready", 32'(w_in_ready), 32'd1);
    tick();
    chk("bp_next_data",  32'(w_data_out), 32'h44);
    chk("bp_next_count", 32'(w_cnt), 32'd1);
    w_drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    chk("drain_valid", 32'(w_out_valid), 32'd0);
    chk("drain_hold",  32'(w_data_out), 32'h44);

    // Synchronous reset mid-stream, then unkeyed traffic and counter wrap
    w_drive(1'b1, 8'h12, 1'b0, 8'h00, 1'b0);
    tick();
    chk("pre_rst_data",  32'(w_data_out), 32'hB8);
    chk("pre_rst_valid", 32'(w_out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(w_out_valid), 32'd0);
    chk("rst_data",  32'(w_data_out), 32'd0);
    chk("rst_count", 32'(w_cnt), 32'd0);
    w_drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    tick();
    chk("post_rst_data",  32'(w_data_out), 32'h5A);
    chk("post_rst_count", 32'(w_cnt), 32'd1);
    for (int k = 2; k <= 17; k++) begin
      w_drive(1'b1, 8'(k * 7), 1'b0, 8'h00, 1'b1);
      tick();
      chk("wrap_count", 32'(w_cnt), 32'(k % 16));
      chk("wrap_data",  32'(w_data_out), 32'(8'(k * 7)));
    end

    // Random traffic against a one-slot reference model
    do_reset();
    m_key = 8'h00; m_d = 8'h00; m_v = 1'b0; m_cnt = 0;
    for (int n = 0; n < 300; n++) begin
      w_drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 8) == 0,
              8'($urandom), ($urandom % 3) != 0);
      #1;
      exp_rdy = !m_v || w_out_ready;
      chk("rnd_in_ready", 32'(w_in_ready), 32'(exp_rdy));
      acc  = w_in_valid && exp_rdy;
      keff = w_key_load ? w_key : m_key;
      if (acc) begin
        m_d = w_data_in ^ keff;
        m_v = 1'b1;
      end else if (w_out_ready) begin
        m_v = 1'b0;
      end
      if (w_key_load) begin
        m_key = acc ? 8'(rotl1(64'(keff), 8)) : w_key;
        m_cnt = acc ? 1 : 0;
      end else if (acc) begin
        m_key = 8'(rotl1(64'(m_key), 8));
        m_cnt = (m_cnt + 1) % 16;
      end
      tick();
      chk("rnd_out_valid", 32'(w_out_valid), 32'(m_v));
      chk("rnd_data_out",  32'(w_data_out), 32'(m_d));
      chk("rnd_count",     32'(w_cnt), 32'(m_cnt));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
